// File: rtl/memsplit_dma.sv
// MemSplit32 block-copy initiator: reads up to BUF_DEPTH words into a local
// buffer, writes them out, and repeats until the requested length is copied.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; latches src/dst/len
// RD_REQ  | issuing read requests for the current chunk
// RD_WAIT | all reads issued, collecting outstanding responses
// WR_REQ  | writing buffered words to the destination
// FIN     | one-cycle completion: done pulse, irq set
module memsplit_dma #(
  parameter int BUF_DEPTH = 4,
  parameter int LEN_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_bi,
  input  logic [31:0]      dst_addr_bi,
  input  logic [LEN_W-1:0] len_bi,
  input  logic             irq_clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             irq_o,
  output logic             m_req_o,
  output logic             m_we_o,
  output logic [31:0]      m_addr_bo,
  output logic [3:0]       m_be_bo,
  output logic [31:0]      m_wdata_bo,
  input  logic             m_ack_i,
  input  logic             m_resp_i,
  input  logic [31:0]      m_rdata_bi
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   chunk_q, chunk_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   recv_q, recv_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        mem_q [BUF_DEPTH];
  logic [31:0]        mem_d [BUF_DEPTH];
  logic               irq_q, irq_d;

  logic               take_resp;
  logic [CNT_W-1:0]   wr_cnt;

  function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(BUF_DEPTH)) return CNT_W'(BUF_DEPTH);
    else                        return n[CNT_W-1:0];
  endfunction

  // Responses only count while a read of this chunk is still outstanding.
  assign take_resp = ((state_q == RD_REQ) || (state_q == RD_WAIT)) &&
                     m_resp_i && (recv_q != issued_q);
  assign wr_cnt    = {1'b0, rd_ptr_q} + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    irq_d    = irq_q;

    if (irq_clr_i)         irq_d = 1'b0;
    if (state_q == FIN)    irq_d = 1'b1;

    if (take_resp) begin
      mem_d[wr_ptr_q] = m_rdata_bi;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      recv_d          = recv_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d    = src_addr_bi;
          dst_d    = dst_addr_bi;
          rem_d    = len_bi;
          chunk_d  = chunk_of(len_bi);
          issued_d = '0;
          recv_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = (len_bi == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        if (m_ack_i) begin
          src_d    = src_q + 32'd4;
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == chunk_q)
            state_d = (recv_d == chunk_q) ? WR_REQ : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (recv_d == chunk_q) state_d = WR_REQ;
      end
      WR_REQ: begin
        if (m_ack_i) begin
          dst_d    = dst_q + 32'd4;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          rem_d    = rem_q - LEN_W'(1);
          if (wr_cnt == chunk_q) begin
            if (rem_d == '0) begin
              state_d = FIN;
            end else begin
              state_d  = RD_REQ;
              chunk_d  = chunk_of(rem_d);
              issued_d = '0;
              recv_d   = '0;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      irq_q    <= irq_d;
      mem_q    <= mem_d;
    end
  end

  // Byte offsets are carried in src/dst but never reach the bus.
  assign m_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign m_we_o     = (state_q == WR_REQ);
  assign m_addr_bo  = (state_q == WR_REQ) ? {dst_q[31:2], 2'b00} :
                      (state_q == RD_REQ) ? {src_q[31:2], 2'b00} : 32'h0;
  assign m_be_bo    = m_req_o ? 4'hF : 4'h0;
  assign m_wdata_bo = (state_q == WR_REQ) ? mem_q[rd_ptr_q] : 32'h0;
  assign busy_o     = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                      (state_q == WR_REQ);
  assign done_o     = (state_q == FIN);
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_memsplit_dma.sv
// Scoreboard bench for memsplit_dma: stimulus pushes the expected bus
// transactions, a MemSplit32 slave model answers, a monitor pops and compares.
module tb_memsplit_dma;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_addr_bi, dst_addr_bi;
  logic [15:0] len_bi;
  logic        irq_clr_i;
  logic        busy_o, done_o, irq_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_bo, m_wdata_bo;
  logic [3:0]  m_be_bo;
  logic        m_ack_i, m_resp_i;
  logic [31:0] m_rdata_bi;

  memsplit_dma #(.BUF_DEPTH(4), .LEN_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_addr_bi(src_addr_bi), .dst_addr_bi(dst_addr_bi), .len_bi(len_bi),
    .irq_clr_i(irq_clr_i), .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_bo(m_addr_bo),
    .m_be_bo(m_be_bo), .m_wdata_bo(m_wdata_bo), .m_ack_i(m_ack_i),
    .m_resp_i(m_resp_i), .m_rdata_bi(m_rdata_bi)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  bit bp_mode = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(logic [31:0] src, logic [31:0] dst, int len);
    logic [31:0] s, d;
    int rem, c;
    exp_t e;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    rem = len;
    while (rem > 0) begin
      c = (rem > 4) ? 4 : rem;
      for (int i = 0; i < c; i++) begin
        e.we = 1'b0; e.addr = s + 32'(4 * i); e.data = 32'h0;
        exp_q.push_back(e);
      end
      for (int i = 0; i < c; i++) begin
        e.we = 1'b1; e.addr = d + 32'(4 * i);
        e.data = (s + 32'(4 * i)) ^ 32'hA5A5_A5A5;
        exp_q.push_back(e);
      end
      s = s + 32'(4 * c);
      d = d + 32'(4 * c);
      rem = rem - c;
    end
  endfunction

  // Slave model: random or immediate ack, in-order read responses.
  initial begin : slave
    int step;
    int last_due;
    logic last_req, last_we;
    logic [31:0] last_addr;
    rsp_t r;
    step = 0; last_due = 0; last_req = 1'b0; last_we = 1'b0; last_addr = 32'h0;
    m_ack_i = 1'b0; m_resp_i = 1'b0; m_rdata_bi = 32'h0;
    forever begin
      @(posedge clk_i); #1;
      step++;
      if (!rst_i) begin
        rsp_q.delete();
        last_req = 1'b0;
        m_ack_i = 1'b0;
        m_resp_i = 1'b0;
      end else begin
        if (last_req && m_ack_i && !last_we) begin
          r.addr = last_addr;
          r.due = step + (bp_mode ? int'($urandom_range(0, 5)) : 0);
          if (r.due < last_due) r.due = last_due;
          last_due = r.due;
          rsp_q.push_back(r);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= step) begin
          r = rsp_q.pop_front();
          m_resp_i = 1'b1;
          m_rdata_bi = r.addr ^ 32'hA5A5_A5A5;
        end else begin
          m_resp_i = 1'b0;
          m_rdata_bi = 32'hDEAD_BEEF;
        end
        last_req = m_req_o;
        last_we = m_we_o;
        last_addr = m_addr_bo;
        m_ack_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request.
  initial begin : monitor
    logic prev_pend;
    logic [31:0] p_addr, p_wdata;
    logic p_we;
    exp_t e;
    prev_pend = 1'b0; p_addr = 32'h0; p_wdata = 32'h0; p_we = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prev_pend = 1'b0;
      end else begin
        if (done_o) done_cnt++;
        if (m_req_o) begin
          chk("be", {28'h0, m_be_bo}, 32'hF);
          if (prev_pend) begin
            chk("hold_addr", m_addr_bo, p_addr);
            chk("hold_we", {31'h0, m_we_o}, {31'h0, p_we});
            if (m_we_o) chk("hold_wdata", m_wdata_bo, p_wdata);
          end
          if (m_ack_i) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_req", m_addr_bo, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("req_we", {31'h0, m_we_o}, {31'h0, e.we});
              chk("req_addr", m_addr_bo, e.addr);
              if (e.we) begin
                chk("req_wdata", m_wdata_bo, e.data);
                last_waddr = m_addr_bo;
                wr_cnt++;
              end
            end
          end
        end
        prev_pend = m_req_o && !m_ack_i;
        p_addr = m_addr_bo; p_we = m_we_o; p_wdata = m_wdata_bo;
      end
    end
  end

  task automatic start_xfer(logic [31:0] src, logic [31:0] dst, logic [15:0] len);
    @(posedge clk_i); #1;
    src_addr_bi = src; dst_addr_bi = dst; len_bi = len; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 3000 cycles", nm);
    end else begin
      chk({nm, "_busy_at_fin"}, {31'h0, busy_o}, 32'h0);
    end
  endtask

  task automatic clear_irq();
    @(posedge clk_i); #1; irq_clr_i = 1'b1;
    @(posedge clk_i); #1; irq_clr_i = 1'b0;
  endtask

  task automatic run_copy(string nm, logic [31:0] src, logic [31:0] dst, int len);
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    push_exp(src, dst, len);
    start_xfer(src, dst, 16'(len));
    wait_done(nm);
    @(posedge clk_i); #1;
    chk({nm, "_irq"}, {31'h0, irq_o}, 32'h1);
    chk({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'h1);
    chk({nm, "_writes"}, 32'(wr_cnt - w0), 32'(len));
  endtask

  initial begin : stim
    int d0, w0;
    bit hit;
    rst_i = 1'b0; start_i = 1'b0; src_addr_bi = 32'h0; dst_addr_bi = 32'h0;
    len_bi = 16'h0; irq_clr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", {31'h0, m_req_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_addr", m_addr_bo, 32'h0);
    chk("rst_be", {28'h0, m_be_bo}, 32'h0);
    @(negedge clk_i); rst_i = 1'b1;

    // Basic copy with first-request latency check.
    d0 = done_cnt; w0 = wr_cnt;
    push_exp(32'h100, 32'h200, 3);
    start_xfer(32'h100, 32'h200, 16'd3);
    chk("latency_req", {31'h0, m_req_o}, 32'h1);
    chk("latency_busy", {31'h0, busy_o}, 32'h1);
    wait_done("basic");
    @(posedge clk_i); #1;
    chk("basic_irq", {31'h0, irq_o}, 32'h1);
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'h1);
    chk("basic_writes", 32'(wr_cnt - w0), 32'd3);
    clear_irq();
    chk("irq_cleared", {31'h0, irq_o}, 32'h0);

    run_copy("multi", 32'h1000, 32'h200, 10);
    chk("multi_last_dst", last_waddr, 32'h224);

    bp_mode = 1'b1;
    run_copy("backpressure", 32'h2004, 32'h3000, 7);
    bp_mode = 1'b0;

    run_copy("wrap", 32'hFFFF_FFF8, 32'h303, 3);
    chk("wrap_last_dst", last_waddr, 32'h308);

    // Zero length: FIN right after start, no bus traffic.
    start_xfer(32'h500, 32'h600, 16'd0);
    chk("len0_done", {31'h0, done_o}, 32'h1);
    chk("len0_busy", {31'h0, busy_o}, 32'h0);
    chk("len0_req", {31'h0, m_req_o}, 32'h0);
    @(posedge clk_i); #1;
    chk("len0_done_gone", {31'h0, done_o}, 32'h0);
    chk("len0_busy_after", {31'h0, busy_o}, 32'h0);

    // Start while busy must not disturb the running transfer.
    d0 = done_cnt; w0 = wr_cnt;
    push_exp(32'h400, 32'h500, 6);
    start_xfer(32'h400, 32'h500, 16'd6);
    repeat (3) @(posedge clk_i);
    start_xfer(32'h900, 32'h990, 16'd2);
    wait_done("midstart");
    repeat (4) @(posedge clk_i);
    #1;
    chk("midstart_writes", 32'(wr_cnt - w0), 32'd6);
    chk("midstart_done_cnt", 32'(done_cnt - d0), 32'h1);
    chk("midstart_idle", {31'h0, busy_o}, 32'h0);

    // irq clear coinciding with FIN: set wins.
    clear_irq();
    chk("irq_pre", {31'h0, irq_o}, 32'h0);
    push_exp(32'h40, 32'h80, 2);
    start_xfer(32'h40, 32'h80, 16'd2);
    wait_done("irqrace");
    irq_clr_i = 1'b1;
    @(posedge clk_i); #1;
    irq_clr_i = 1'b0;
    chk("irqrace_set_wins", {31'h0, irq_o}, 32'h1);
    clear_irq();
    chk("irqrace_cleared", {31'h0, irq_o}, 32'h0);

    // Asynchronous reset while writing.
    push_exp(32'h600, 32'h700, 8);
    start_xfer(32'h600, 32'h700, 16'd8);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk_i); #1;
      if (m_req_o && m_we_o) hit = 1'b1;
    end
    chk("wrreq_reached", {31'h0, hit}, 32'h1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_req", {31'h0, m_req_o}, 32'h0);
    chk("arst_we", {31'h0, m_we_o}, 32'h0);
    chk("arst_addr", m_addr_bo, 32'h0);
    chk("arst_wdata", m_wdata_bo, 32'h0);
    chk("arst_be", {28'h0, m_be_bo}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_done", {31'h0, done_o}, 32'h0);
    chk("arst_irq", {31'h0, irq_o}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    run_copy("post_reset", 32'h800, 32'h810, 1);
    chk("post_reset_dst", last_waddr, 32'h810);

    repeat (5) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
